memory_arbiter: RTL and testbench

Shares the single byte-serial memory controller (memory_control_synth) between two requesters: instruction fetch and data load/store. The block arbitrates between them, latches the winner's command, pulses the controller's start, waits for its done, and returns read data and a one-cycle done to the winner. It sits between the CPU core's fetch/LSU stages and the memory controller.

---
 rtl/memory_arbiter_pkg.sv | 27 ++
 rtl/mem_arb_select.sv | 14 +
 rtl/memory_arbiter.sv | 175 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared FUNC3 encodings and the mode legality check for the memory arbiter.
// FUNC3 macros are guarded by ARCH_DEFINES so other core files may define them first.
`ifndef ARCH_DEFINES
`define ARCH_DEFINES
`define LB  3'b000
`define LH  3'b001
`define LW  3'b010
`define LBU 3'b100
`define LHU 3'b101
`define SB  3'b000
`define SH  3'b001
`define SW  3'b010
`endif

package memory_arbiter_pkg;

    localparam logic [2:0] FETCH_MODE = `LW;

    // Loads accept any load FUNC3; stores additionally reject the unsigned forms.
    function automatic logic mode_illegal(input logic [2:0] mode, input logic we);
        logic ld_ok, st_ok;
        ld_ok = mode inside {`LB, `LH, `LW, `LBU, `LHU};
        st_ok = mode inside {`SB, `SH, `SW};
        return !ld_ok || (we && !st_ok);
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant selection between fetch and data requesters.
// rr_i = 1 prefers data on a tie; tie it high for fixed data priority.
module mem_arb_select (
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic rr_i,
    output logic grant_d_o,
    output logic grant_if_o
);

    assign grant_d_o  = d_req_i & (rr_i | ~if_req_i);
    assign grant_if_o = if_req_i & ~grant_d_o;

endmodule

// File: rtl/memory_arbiter.sv
// Shares one byte-serial memory controller between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_mode,
    input  logic              d_we,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_start,
    output logic [ADDR_W-1:0] mem_address,
    output logic [2:0]        mem_mode,
    output logic              mem_write_enable,
    output logic [31:0]       mem_write_data,
    input  logic              mem_done,
    input  logic [31:0]       mem_read_data,
    input  logic              mem_active
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = data owns the current access
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        mode_q, mode_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rr_ptr, grant_d, grant_if;

`ifdef MEM_ARB_RR_EN
    logic rr_q, rr_d;
    assign rr_ptr = rr_q;
`else
    assign rr_ptr = 1'b1;
`endif

    mem_arb_select u_sel (
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .rr_i      (rr_ptr),
        .grant_d_o (grant_d),
        .grant_if_o(grant_if)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                // A controller still busy from before reset must finish first.
                if (!mem_active && (grant_d || grant_if)) begin
                    owner_d = grant_d;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (grant_d) begin
                        addr_d  = d_addr;
                        mode_d  = d_mode;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = if_addr;
                        mode_d  = FETCH_MODE;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    if (grant_d && mode_illegal(d_mode, d_we)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_done) begin
                    rdata_d = we_q ? '0 : mem_read_data;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
`ifdef MEM_ARB_RR_EN
                rr_d    = ~owner_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            mode_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    logic resp_if, resp_d;
    assign resp_if = (state_q == RESP) && !owner_q;
    assign resp_d  = (state_q == RESP) && owner_q;

    assign mem_start        = (state_q == ISSUE);
    assign mem_address      = addr_q;
    assign mem_mode         = mode_q;
    assign mem_write_enable = we_q;
    assign mem_write_data   = wdata_q;

    assign if_done  = resp_if;
    assign if_rdata = resp_if ? rdata_q : '0;
    assign if_err   = resp_if & err_q;
    assign d_done   = resp_d;
    assign d_rdata  = resp_d ? rdata_q : '0;
    assign d_err    = resp_d & err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a negedge controller model.
module tb_memory_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [2:0]  d_mode = 0;
    logic        if_done, if_err, d_done, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_start, mem_write_enable;
    logic [31:0] mem_address, mem_write_data;
    logic [2:0]  mem_mode;
    logic        mem_done = 0, mem_active = 0;
    logic [31:0] mem_read_data = 0;

    int tests = 0, fails = 0;

    // Controller model: mem_done pulses lat cycles after the start cycle; lat=0 never answers.
    int          lat = 0, rem = 0, start_cnt = 0;
    logic [31:0] mdata = 0;
    logic [31:0] st_addr;
    logic [2:0]  st_mode;
    logic        st_we;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_addr(d_addr), .d_mode(d_mode), .d_we(d_we), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_start(mem_start), .mem_address(mem_address), .mem_mode(mem_mode),
        .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
        .mem_done(mem_done), .mem_read_data(mem_read_data), .mem_active(mem_active)
    );

    always @(negedge clk) begin
        mem_done = 1'b0;
        if (!rst_n) rem = 0;
        else begin
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) begin mem_done = 1'b1; mem_read_data = mdata; end
            end
            if (mem_start) begin
                start_cnt = start_cnt + 1;
                st_addr = mem_address; st_mode = mem_mode; st_we = mem_write_enable;
                if (lat > 0) rem = lat;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({if_done, if_err, if_rdata, d_done, d_err, d_rdata, mem_start, mem_address,
             mem_mode, mem_write_enable, mem_write_data} !== '0) begin
            fails++; $display("FAIL reset_outputs: outputs not all zero during reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int base, at; logic [31:0] rd; logic er, dseen;
        lat = 4; mdata = 32'hDEADBEEF; base = start_cnt; at = -1; rd = 0; er = 1; dseen = 0;
        if_req = 1; if_addr = 32'h100;
        for (int i = 0; i < 30 && at < 0; i++) begin
            @(negedge clk);
            if (d_done) dseen = 1;
            if (if_done) begin at = i; rd = if_rdata; er = if_err; if_req = 0; end
        end
        tests++; if (at != 5) begin fails++; $display("FAIL fetch_latency: got %0d want 5", at); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_rdata: got %h want deadbeef", rd); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL fetch_err: got %b want 0", er); end
        tests++; if (start_cnt - base != 1) begin fails++; $display("FAIL fetch_starts: got %0d want 1", start_cnt - base); end
        tests++; if ({st_mode, st_we} !== 4'b0100) begin fails++; $display("FAIL fetch_cmd: mode/we got %b%b want 0100", st_mode, st_we); end
        tests++; if (st_addr !== 32'h100) begin fails++; $display("FAIL fetch_addr: got %h want 100", st_addr); end
        tests++; if (dseen !== 1'b0) begin fails++; $display("FAIL fetch_d_done: d_done pulsed during fetch"); end
        @(negedge clk);
        tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL fetch_one_cycle: if_done still high"); end
    endtask

    task automatic test_store();
        int at; logic er, ifseen; logic [31:0] rd;
        lat = 2; mdata = 32'hFFFF0000; at = -1; er = 1; ifseen = 0; rd = 32'hx;
        d_req = 1; d_addr = 32'h203; d_mode = 3'b000; d_we = 1; d_wdata = 32'h000000A5;
        for (int i = 0; i < 30 && at < 0; i++) begin
            @(negedge clk);
            if (i < 2) begin
                tests++;
                if ({mem_start, mem_address, mem_mode, mem_write_enable, mem_write_data} !==
                    {(i == 0), 32'h203, 3'b000, 1'b1, 32'h000000A5}) begin
                    fails++; $display("FAIL store_cmd_c%0d: start=%b addr=%h mode=%b we=%b wd=%h", i,
                        mem_start, mem_address, mem_mode, mem_write_enable, mem_write_data);
                end
            end
            if (if_done) ifseen = 1;
            if (d_done) begin at = i; er = d_err; rd = d_rdata; d_req = 0; end
        end
        tests++; if (at != 3) begin fails++; $display("FAIL store_latency: got %0d want 3", at); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL store_err: got %b want 0", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL store_rdata: got %h want 0", rd); end
        tests++; if (ifseen !== 1'b0) begin fails++; $display("FAIL store_if_done: if_done pulsed"); end
        @(negedge clk);
    endtask

    task automatic test_load();
        int at; logic [31:0] rd;
        lat = 1; mdata = 32'h12345678; at = -1; rd = 0;
        d_req = 1; d_addr = 32'h400; d_mode = 3'b010; d_we = 0;
        for (int i = 0; i < 30 && at < 0; i++) begin
            @(negedge clk);
            if (d_done) begin at = i; rd = d_rdata; d_req = 0; end
        end
        tests++; if (at != 2) begin fails++; $display("FAIL load_latency: got %0d want 2", at); end
        tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL load_rdata: got %h want 12345678", rd); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int base, nd, ni; logic first_d, both; logic first_set;
`ifdef MEM_ARB_RR_EN
        logic exp_first_d = 1'b0;
`else
        logic exp_first_d = 1'b1;
`endif
        lat = 2; mdata = 32'h0BADF00D; base = start_cnt; nd = 0; ni = 0;
        first_d = 0; first_set = 0; both = 0;
        if_req = 1; if_addr = 32'h500;
        d_req = 1; d_addr = 32'h600; d_mode = 3'b010; d_we = 0;
        for (int i = 0; i < 40 && (nd == 0 || ni == 0); i++) begin
            @(negedge clk);
            if (if_done && d_done) both = 1;
            if (d_done) begin nd++; if (!first_set) begin first_d = 1; first_set = 1; end d_req = 0; end
            if (if_done) begin ni++; if (!first_set) begin first_d = 0; first_set = 1; end if_req = 0; end
        end
        tests++; if (nd != 1 || ni != 1) begin fails++; $display("FAIL simul_served: d=%0d if=%0d want 1 1", nd, ni); end
        tests++; if (first_d !== exp_first_d) begin fails++; $display("FAIL simul_order: first_is_data=%b want %b", first_d, exp_first_d); end
        tests++; if (both !== 1'b0) begin fails++; $display("FAIL simul_overlap: both done together"); end
        tests++; if (start_cnt - base != 2) begin fails++; $display("FAIL simul_starts: got %0d want 2", start_cnt - base); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [3:0] vec [2];
        vec[0] = 4'b1110;   // mode 111 load
        vec[1] = 4'b1001;   // LBU encoding as a store
        for (int k = 0; k < 2; k++) begin
            int base, at; logic er; logic [31:0] rd;
            lat = 2; mdata = 32'h55555555; base = start_cnt; at = -1; er = 0; rd = 32'hx;
            d_req = 1; d_addr = 32'h700; d_mode = vec[k][3:1]; d_we = vec[k][0]; d_wdata = 32'h77;
            for (int i = 0; i < 10 && at < 0; i++) begin
                @(negedge clk);
                if (d_done) begin at = i; er = d_err; rd = d_rdata; d_req = 0; end
            end
            tests++; if (at != 0) begin fails++; $display("FAIL illegal%0d_latency: got %0d want 0", k, at); end
            tests++; if (er !== 1'b1) begin fails++; $display("FAIL illegal%0d_err: got %b want 1", k, er); end
            tests++; if (rd !== 32'h0) begin fails++; $display("FAIL illegal%0d_rdata: got %h want 0", k, rd); end
            tests++; if (start_cnt != base) begin fails++; $display("FAIL illegal%0d_start: got %0d starts want 0", k, start_cnt - base); end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int base, at; logic er; logic [31:0] rd;
        lat = 0; base = start_cnt; at = -1; er = 0; rd = 32'hx;
        d_req = 1; d_addr = 32'h800; d_mode = 3'b001; d_we = 0;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(negedge clk);
            if (d_done) begin at = i; er = d_err; rd = d_rdata; d_req = 0; end
        end
        // Cycle 0 is ISSUE, so WAIT starts at cycle 1 and RESP lands TIMEOUT cycles later.
        tests++; if (at != TIMEOUT + 1) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", at, TIMEOUT + 1); end
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL timeout_rdata: got %h want 0", rd); end
        tests++; if (start_cnt - base != 1) begin fails++; $display("FAIL timeout_starts: got %0d want 1", start_cnt - base); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int at; logic early; logic [31:0] rd;
        lat = 0; at = -1; early = 0; rd = 0;
        if_req = 1; if_addr = 32'h300;
        repeat (4) @(negedge clk);
        rst_n = 0; mem_active = 1;
        @(negedge clk);
        tests++;
        if ({if_done, if_err, if_rdata, d_done, d_err, d_rdata, mem_start, mem_address,
             mem_mode, mem_write_enable, mem_write_data} !== '0) begin
            fails++; $display("FAIL midreset_outputs: outputs not all zero during reset");
        end
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            if (mem_start) early = 1;
        end
        tests++; if (early !== 1'b0) begin fails++; $display("FAIL midreset_guard: mem_start while mem_active"); end
        mem_active = 0; lat = 2; mdata = 32'hCAFEF00D;
        for (int i = 0; i < 30 && at < 0; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tests++; if (mem_start !== 1'b1) begin fails++; $display("FAIL midreset_start: got %b want 1", mem_start); end
            end
            if (if_done) begin at = i; rd = if_rdata; if_req = 0; end
        end
        tests++; if (at != 3) begin fails++; $display("FAIL midreset_latency: got %0d want 3", at); end
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL midreset_rdata: got %h want cafef00d", rd); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_simultaneous();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
